// File: rtl/timer_bank.sv
// timer_bank: bank of CHANNELS independent prescaled up/down timers behind a
// word-addressed register bus with one-cycle read latency.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous active-high reset
//   reg_read       read strobe (one cycle per access)
//   reg_write      write strobe (one cycle per access)
//   reg_address    word address {channel, reg[1:0]}
//   reg_data_in    write data
//   reg_read_valid pulses the cycle after reg_read
//   reg_data_out   read data, held until the next read
//   irq            registered OR over channels of (flag & irq_en)
//
// Per-channel registers: 0 COUNT, 1 CONFIG, 2 RELOAD, 3 STATUS (W1C flag).
module timer_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    localparam int unsigned ADDR_WIDTH =
        (($clog2(CHANNELS) + 2) < 3) ? 3 : ($clog2(CHANNELS) + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_read,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] reg_address,
    input  logic [31:0]           reg_data_in,
    output logic                  reg_read_valid,
    output logic [31:0]           reg_data_out,
    output logic                  irq
);

    localparam int unsigned CH_W   = ADDR_WIDTH - 2;
    localparam int unsigned PS_W   = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_CONFIG = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Per-channel control fields as stored (unimplemented CONFIG bits dropped).
    typedef struct packed {
        logic [PS_W-1:0] prescale;
        logic            one_shot;
        logic            irq_en;
        logic            dir;
        logic            enable;
    } cfg_t;

    // Architectural state
    logic [WIDTH-1:0] count_q  [CHANNELS];
    logic [WIDTH-1:0] reload_q [CHANNELS];
    cfg_t             cfg_q    [CHANNELS];
    logic [PS_W-1:0]  pcnt_q   [CHANNELS];
    logic [CHANNELS-1:0] flag_q;

    // Bus decode
    logic [CH_W-1:0]  addr_ch_c;
    logic [1:0]       addr_reg_c;
    logic [WIDTH-1:0] wdata_c;
    cfg_t             cfg_wdata_c;

    logic [CHANNELS-1:0] wr_count_c;
    logic [CHANNELS-1:0] wr_config_c;
    logic [CHANNELS-1:0] wr_reload_c;
    logic [CHANNELS-1:0] wr_status_c;

    // Counter datapath
    logic [CHANNELS-1:0] tick_c;
    logic [CHANNELS-1:0] at_wrap_c;
    logic [CHANNELS-1:0] event_c;
    logic [CHANNELS-1:0] irq_src_c;
    logic [WIDTH-1:0]    count_nxt_c [CHANNELS];
    logic [PS_W-1:0]     pcnt_nxt_c  [CHANNELS];

    logic [DATA_W-1:0]   rdata_c;

    assign addr_ch_c   = reg_address[ADDR_WIDTH-1:2];
    assign addr_reg_c  = reg_address[1:0];
    assign wdata_c     = reg_data_in[WIDTH-1:0];
    assign cfg_wdata_c = {reg_data_in[31:16], reg_data_in[3:0]};

    // Write strobes per channel; channel indices beyond CHANNELS match nothing.
    always_comb begin
        wr_count_c  = '0;
        wr_config_c = '0;
        wr_reload_c = '0;
        wr_status_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (reg_write && (addr_ch_c == CH_W'(c))) begin
                wr_count_c[c]  = (addr_reg_c == REG_COUNT);
                wr_config_c[c] = (addr_reg_c == REG_CONFIG);
                wr_reload_c[c] = (addr_reg_c == REG_RELOAD);
                wr_status_c[c] = (addr_reg_c == REG_STATUS);
            end
        end
    end

    // Prescaler tick, wrap detection and next count per channel.
    always_comb begin
        tick_c    = '0;
        at_wrap_c = '0;
        event_c   = '0;
        irq_src_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count_nxt_c[c] = count_q[c];
            pcnt_nxt_c[c]  = pcnt_q[c];

            tick_c[c] = cfg_q[c].enable && (pcnt_q[c] == cfg_q[c].prescale);
            if (cfg_q[c].enable) begin
                pcnt_nxt_c[c] = tick_c[c] ? '0 : pcnt_q[c] + PS_W'(1);
            end

            // Up mode past RELOAD simply rolls over at 2^WIDTH with no event.
            if (cfg_q[c].dir) begin
                at_wrap_c[c]   = (count_q[c] == reload_q[c]);
                count_nxt_c[c] = at_wrap_c[c] ? '0 : count_q[c] + WIDTH'(1);
            end else begin
                at_wrap_c[c]   = (count_q[c] == '0);
                count_nxt_c[c] = at_wrap_c[c] ? reload_q[c] : count_q[c] - WIDTH'(1);
            end

            // A software COUNT write on the tick edge overrides the wrap and its event.
            event_c[c]   = tick_c[c] && at_wrap_c[c] && !wr_count_c[c];
            irq_src_c[c] = flag_q[c] && cfg_q[c].irq_en;
        end
    end

    // Read mux over pre-edge state; unmapped channels read as zero.
    always_comb begin
        rdata_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr_ch_c == CH_W'(c)) begin
                case (addr_reg_c)
                    REG_COUNT:  rdata_c = DATA_W'(count_q[c]);
                    REG_CONFIG: rdata_c = {cfg_q[c].prescale, 12'd0, cfg_q[c].one_shot,
                                           cfg_q[c].irq_en, cfg_q[c].dir, cfg_q[c].enable};
                    REG_RELOAD: rdata_c = DATA_W'(reload_q[c]);
                    default:    rdata_c = {30'd0, cfg_q[c].enable, flag_q[c]};
                endcase
            end
        end
    end

    // Channel state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
                cfg_q[c]    <= '0;
                pcnt_q[c]   <= '0;
            end
            flag_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_count_c[c]) begin
                    count_q[c] <= wdata_c;
                end else if (tick_c[c]) begin
                    count_q[c] <= count_nxt_c[c];
                end

                if (wr_reload_c[c]) begin
                    reload_q[c] <= wdata_c;
                end

                // CONFIG writes restart the prescaler and override a one-shot stop.
                if (wr_config_c[c]) begin
                    cfg_q[c]  <= cfg_wdata_c;
                    pcnt_q[c] <= '0;
                end else begin
                    pcnt_q[c] <= pcnt_nxt_c[c];
                    if (event_c[c] && cfg_q[c].one_shot) begin
                        cfg_q[c].enable <= 1'b0;
                    end
                end

                // Set beats W1C when both land on the same edge.
                flag_q[c] <= event_c[c] | (flag_q[c] & ~(wr_status_c[c] & reg_data_in[0]));
            end
        end
    end

    // Registered bus response and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_read_valid <= 1'b0;
            reg_data_out   <= '0;
            irq            <= 1'b0;
        end else begin
            reg_read_valid <= reg_read;
            if (reg_read) begin
                reg_data_out <= rdata_c;
            end
            irq <= |irq_src_c;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: instance A (3 channels, 32-bit) and instance B
// (16 channels, 8-bit). Expected read data is queued when a read is issued
// and compared when reg_read_valid comes back.
module tb_timer_bank;

    localparam logic [1:0] R_COUNT  = 2'd0;
    localparam logic [1:0] R_CONFIG = 2'd1;
    localparam logic [1:0] R_RELOAD = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic clk = 1'b0;
    logic reset;

    logic        a_read, a_write, a_valid, a_irq;
    logic [3:0]  a_addr;
    logic [31:0] a_din, a_dout;

    logic        b_read, b_write, b_valid, b_irq;
    logic [5:0]  b_addr;
    logic [31:0] b_din, b_dout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] a_exp_q[$];
    string       a_nm_q[$];
    logic [31:0] b_exp_q[$];
    string       b_nm_q[$];

    always #5 clk = ~clk;

    timer_bank #(.CHANNELS(3), .WIDTH(32)) dut_a (
        .clk(clk), .reset(reset),
        .reg_read(a_read), .reg_write(a_write), .reg_address(a_addr),
        .reg_data_in(a_din), .reg_read_valid(a_valid), .reg_data_out(a_dout),
        .irq(a_irq)
    );

    timer_bank #(.CHANNELS(16), .WIDTH(8)) dut_b (
        .clk(clk), .reset(reset),
        .reg_read(b_read), .reg_write(b_write), .reg_address(b_addr),
        .reg_data_in(b_din), .reg_read_valid(b_valid), .reg_data_out(b_dout),
        .irq(b_irq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic rd, input logic wr, input logic [1:0] ch,
                        input logic [1:0] rg, input logic [31:0] wd,
                        input logic [31:0] exp, input string nm);
        a_read  = rd;
        a_write = wr;
        a_addr  = {ch, rg};
        a_din   = wd;
        if (rd) begin
            a_exp_q.push_back(exp);
            a_nm_q.push_back(nm);
        end
        cyc();
        a_read  = 1'b0;
        a_write = 1'b0;
    endtask

    task automatic a_wr(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] wd);
        a_op(1'b0, 1'b1, ch, rg, wd, 32'd0, "");
    endtask

    task automatic a_rd(input logic [1:0] ch, input logic [1:0] rg,
                        input logic [31:0] exp, input string nm);
        a_op(1'b1, 1'b0, ch, rg, 32'd0, exp, nm);
    endtask

    task automatic b_op(input logic rd, input logic wr, input logic [3:0] ch,
                        input logic [1:0] rg, input logic [31:0] wd,
                        input logic [31:0] exp, input string nm);
        b_read  = rd;
        b_write = wr;
        b_addr  = {ch, rg};
        b_din   = wd;
        if (rd) begin
            b_exp_q.push_back(exp);
            b_nm_q.push_back(nm);
        end
        cyc();
        b_read  = 1'b0;
        b_write = 1'b0;
    endtask

    task automatic b_wr(input logic [3:0] ch, input logic [1:0] rg, input logic [31:0] wd);
        b_op(1'b0, 1'b1, ch, rg, wd, 32'd0, "");
    endtask

    task automatic b_rd(input logic [3:0] ch, input logic [1:0] rg,
                        input logic [31:0] exp, input string nm);
        b_op(1'b1, 1'b0, ch, rg, 32'd0, exp, nm);
    endtask

    // Scoreboard: pop the oldest expectation whenever a read response appears.
    task automatic sb_monitor();
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                n_checks++;
                if (a_exp_q.size() == 0) begin
                    $display("FAIL a_spurious_valid: got data %h, required no response", a_dout);
                end else begin
                    e  = a_exp_q.pop_front();
                    nm = a_nm_q.pop_front();
                    if (a_dout !== e) $display("FAIL %s: got %h, required %h", nm, a_dout, e);
                    else n_pass++;
                end
            end
            if (b_valid === 1'b1) begin
                n_checks++;
                if (b_exp_q.size() == 0) begin
                    $display("FAIL b_spurious_valid: got data %h, required no response", b_dout);
                end else begin
                    e  = b_exp_q.pop_front();
                    nm = b_nm_q.pop_front();
                    if (b_dout !== e) $display("FAIL %s: got %h, required %h", nm, b_dout, e);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset();
        // Running channel with a pending interrupt, then reset mid-count.
        a_wr(2'd0, R_RELOAD, 32'd1);
        a_wr(2'd0, R_CONFIG, 32'h7);
        repeat (3) cyc();
        a_rd(2'd0, R_RELOAD, 32'd1, "rst_pre_reload");
        repeat (3) cyc();
        n_checks++;
        if (a_irq !== 1'b1) $display("FAIL rst_pre_irq: got %b, required 1", a_irq);
        else n_pass++;

        reset = 1'b1;
        cyc();
        n_checks++;
        if (a_irq !== 1'b0) $display("FAIL rst_irq_first_edge: got %b, required 0", a_irq);
        else n_pass++;
        n_checks++;
        if (a_dout !== 32'd0 || a_valid !== 1'b0)
            $display("FAIL rst_bus_outputs: got valid=%b data=%h, required 0/0", a_valid, a_dout);
        else n_pass++;
        repeat (9) cyc();
        reset = 1'b0;

        // Channel 3 does not exist on instance A: writes vanish, reads are 0.
        a_wr(2'd3, R_COUNT, 32'hFFFF);
        a_wr(2'd3, R_CONFIG, 32'hFFFF_FFFF);
        for (int ch = 0; ch < 4; ch++) begin
            for (int rg = 0; rg < 4; rg++) begin
                a_rd(2'(ch), 2'(rg), 32'd0, $sformatf("rst_ch%0d_reg%0d", ch, rg));
            end
        end
        n_checks++;
        if (a_irq !== 1'b0) $display("FAIL rst_irq_after: got %b, required 0", a_irq);
        else n_pass++;
    endtask

    task automatic test_up_count();
        a_wr(2'd1, R_RELOAD, 32'd5);
        a_wr(2'd1, R_CONFIG, 32'h7);
        for (int k = 1; k <= 7; k++) begin
            a_rd(2'd1, R_COUNT, (k == 7) ? 32'd0 : 32'(k - 1), $sformatf("up_count_k%0d", k));
            n_checks++;
            if (a_irq !== (k == 7)) $display("FAIL up_irq_k%0d: got %b, required %b", k, a_irq, (k == 7));
            else n_pass++;
        end
        a_rd(2'd1, R_STATUS, 32'd3, "up_status_flag");
        a_wr(2'd1, R_STATUS, 32'd1);
        n_checks++;
        if (a_irq !== 1'b1) $display("FAIL up_irq_w1c_edge: got %b, required 1", a_irq);
        else n_pass++;
        cyc();
        n_checks++;
        if (a_irq !== 1'b0) $display("FAIL up_irq_cleared: got %b, required 0", a_irq);
        else n_pass++;
        a_wr(2'd1, R_CONFIG, 32'd0);
        a_rd(2'd1, R_STATUS, 32'd0, "up_status_after_w1c");
    endtask

    task automatic test_down_prescale();
        logic [31:0] e;
        a_wr(2'd2, R_RELOAD, 32'd3);
        a_wr(2'd2, R_COUNT, 32'd2);
        a_wr(2'd2, R_CONFIG, 32'h0004_0001);
        for (int k = 1; k <= 21; k++) begin
            if (k <= 5)       e = 32'd2;
            else if (k <= 10) e = 32'd1;
            else if (k <= 15) e = 32'd0;
            else if (k <= 20) e = 32'd3;
            else              e = 32'd2;
            a_rd(2'd2, R_COUNT, e, $sformatf("down_count_k%0d", k));
        end
        a_rd(2'd2, R_STATUS, 32'd3, "down_status_flag");
        a_rd(2'd2, R_CONFIG, 32'h0004_0001, "down_config_readback");
        n_checks++;
        if (a_irq !== 1'b0) $display("FAIL down_irq_masked: got %b, required 0", a_irq);
        else n_pass++;
        a_wr(2'd2, R_CONFIG, 32'd0);
        a_wr(2'd2, R_STATUS, 32'd1);
    endtask

    task automatic test_one_shot();
        a_wr(2'd0, R_RELOAD, 32'd2);
        a_wr(2'd0, R_CONFIG, 32'hB);
        repeat (3) cyc();
        a_rd(2'd0, R_COUNT, 32'd0, "oneshot_count");
        a_rd(2'd0, R_CONFIG, 32'hA, "oneshot_enable_cleared");
        a_rd(2'd0, R_STATUS, 32'd1, "oneshot_status");
        repeat (50) cyc();
        a_rd(2'd0, R_COUNT, 32'd0, "oneshot_frozen");
        a_wr(2'd0, R_STATUS, 32'd1);
        a_rd(2'd0, R_STATUS, 32'd0, "oneshot_w1c");
    endtask

    task automatic test_prescale_clear();
        a_wr(2'd2, R_CONFIG, 32'hFFFF_FFF0);
        a_rd(2'd2, R_CONFIG, 32'hFFFF_0000, "cfg_reserved_bits");
        a_wr(2'd2, R_CONFIG, 32'd0);
        a_wr(2'd2, R_COUNT, 32'd10);
        a_wr(2'd2, R_CONFIG, 32'h0003_0001);
        cyc();
        a_wr(2'd2, R_CONFIG, 32'h0003_0001);
        for (int k = 3; k <= 7; k++) begin
            a_rd(2'd2, R_COUNT, (k == 7) ? 32'd9 : 32'd10, $sformatf("pclr_count_k%0d", k));
        end
        a_wr(2'd2, R_CONFIG, 32'd0);
    endtask

    task automatic test_collisions();
        // W1C on the event edge: set wins.
        a_wr(2'd1, R_COUNT, 32'd0);
        a_wr(2'd1, R_RELOAD, 32'd3);
        a_wr(2'd1, R_CONFIG, 32'h3);
        repeat (3) cyc();
        a_wr(2'd1, R_STATUS, 32'd1);
        a_rd(2'd1, R_STATUS, 32'd3, "coll_w1c_vs_event");
        a_wr(2'd1, R_CONFIG, 32'd0);
        a_wr(2'd1, R_STATUS, 32'd1);

        // COUNT write on the wrapping tick edge: write wins, no event.
        a_wr(2'd1, R_COUNT, 32'd0);
        a_wr(2'd1, R_CONFIG, 32'h3);
        repeat (3) cyc();
        a_wr(2'd1, R_COUNT, 32'd7);
        a_rd(2'd1, R_COUNT, 32'd7, "coll_count_write");
        a_rd(2'd1, R_STATUS, 32'd2, "coll_no_event");
        a_wr(2'd1, R_CONFIG, 32'd0);

        // Simultaneous read and write returns the pre-write value.
        a_op(1'b1, 1'b1, 2'd2, R_RELOAD, 32'h1234, 32'd3, "coll_rw_old_value");
        a_rd(2'd2, R_RELOAD, 32'h1234, "coll_rw_new_value");
    endtask

    task automatic test_width_sweep();
        b_wr(4'd0, R_COUNT, 32'h1FF);
        b_rd(4'd0, R_COUNT, 32'hFF, "w8_count_trunc");
        b_wr(4'd0, R_RELOAD, 32'hABCD);
        b_rd(4'd0, R_RELOAD, 32'hCD, "w8_reload_trunc");
        b_wr(4'd0, R_COUNT, 32'hFF);
        b_wr(4'd0, R_RELOAD, 32'h10);
        b_wr(4'd0, R_CONFIG, 32'h3);
        b_rd(4'd0, R_COUNT, 32'hFF, "w8_before_wrap");
        b_rd(4'd0, R_COUNT, 32'h00, "w8_wrapped");
        b_rd(4'd0, R_COUNT, 32'h01, "w8_after_wrap");
        b_rd(4'd0, R_STATUS, 32'd2, "w8_wrap_no_event");
        b_wr(4'd0, R_CONFIG, 32'd0);
        n_checks++;
        if (b_irq !== 1'b0) $display("FAIL w8_irq_idle: got %b, required 0", b_irq);
        else n_pass++;
    endtask

    task automatic test_concurrent_irq();
        for (int c = 0; c < 16; c++) begin
            b_wr(4'(c), R_COUNT, 32'd0);
            b_wr(4'(c), R_RELOAD, 32'd0);
        end
        // Down, one-shot, P=c; only channel 9 has irq_en. Channel c fires 2c+1 edges after the first write.
        for (int c = 0; c < 16; c++) begin
            b_wr(4'(c), R_CONFIG, (32'(c) << 16) | ((c == 9) ? 32'hD : 32'h9));
        end
        for (int j = 16; j <= 22; j++) begin
            cyc();
            n_checks++;
            if (b_irq !== (j >= 20)) $display("FAIL conc_irq_edge%0d: got %b, required %b", j, b_irq, (j >= 20));
            else n_pass++;
        end
        repeat (12) cyc();
        for (int c = 0; c < 16; c++) begin
            b_rd(4'(c), R_STATUS, 32'd1, $sformatf("conc_status_ch%0d", c));
        end
        b_rd(4'd9, R_CONFIG, 32'h0009_000C, "conc_cfg_ch9");
        n_checks++;
        if (b_irq !== 1'b1) $display("FAIL conc_irq_held: got %b, required 1", b_irq);
        else n_pass++;

        b_wr(4'd9, R_STATUS, 32'd1);
        n_checks++;
        if (b_irq !== 1'b1) $display("FAIL conc_irq_w1c_edge: got %b, required 1", b_irq);
        else n_pass++;
        cyc();
        n_checks++;
        if (b_irq !== 1'b0) $display("FAIL conc_irq_cleared: got %b, required 0", b_irq);
        else n_pass++;
        // Unmask channel 3, whose flag is still set.
        b_wr(4'd3, R_CONFIG, 32'h4);
        n_checks++;
        if (b_irq !== 1'b0) $display("FAIL conc_irq_unmask_edge: got %b, required 0", b_irq);
        else n_pass++;
        cyc();
        n_checks++;
        if (b_irq !== 1'b1) $display("FAIL conc_irq_unmasked: got %b, required 1", b_irq);
        else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        a_read  = 1'b0;
        a_write = 1'b0;
        a_addr  = '0;
        a_din   = '0;
        b_read  = 1'b0;
        b_write = 1'b0;
        b_addr  = '0;
        b_din   = '0;
        fork
            sb_monitor();
        join_none
        repeat (3) cyc();
        reset = 1'b0;

        test_reset();
        test_up_count();
        test_down_prescale();
        test_one_shot();
        test_prescale_clear();
        test_collisions();
        test_width_sweep();
        test_concurrent_irq();

        repeat (3) cyc();
        n_checks++;
        if (a_exp_q.size() != 0 || b_exp_q.size() != 0)
            $display("FAIL missing_read_responses: outstanding a=%0d b=%0d, required 0/0",
                     a_exp_q.size(), b_exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer peripheral: CHANNELS independent up/down counters, each with prescaler, reload/compare value, one-shot mode, sticky event flag and maskable interrupt. Sits on the same register-bus port set as `peripheral_top` (reg_read/reg_write, word address, 1-cycle read latency). The aggregate `irq` feeds the system interrupt controller.

## Interface
- CHANNELS, 4, number of timer channels, 1..16
- WIDTH, 32, counter and reload width in bits, 8..32
- ADDR_WIDTH, $clog2(CHANNELS)+2 (min 3), word-address width; derived, not overridden
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- reg_read  input  1  read strobe, one cycle per access
- reg_write  input  1  write strobe, one cycle per access
- reg_address  input  ADDR_WIDTH  word address {channel, reg[1:0]}
- reg_data_in  input  32  write data
- reg_read_valid  output  1  one-cycle pulse, the cycle after reg_read
- reg_data_out  output  32  read data, valid with reg_read_valid, held until next read
- irq  output  1  OR over channels of (flag & irq_en), registered

## Operation
- Per channel, reg[1:0]: 0 COUNT (R/W), 1 CONFIG (R/W), 2 RELOAD (R/W), 3 STATUS (R, W1C).
- CONFIG: [0] enable, [1] dir (1 up, 0 down), [2] irq_en, [3] one_shot, [31:16] prescale P; other bits read 0.
- STATUS: [0] flag (sticky; writing 1 clears), [1] running (= enable, read-only); other bits 0.
- Tick: prescale counter increments each cycle while enable=1; tick when it equals P, then wraps to 0. P=0 gives a tick every cycle.
- Up mode on tick: COUNT==RELOAD → COUNT=0 and event; else COUNT+1.
- Down mode on tick: COUNT==0 → COUNT=RELOAD and event; else COUNT-1.
- Event sets flag. If one_shot, the event also clears enable; COUNT still takes its wrap value.
- Width: writes truncate reg_data_in to WIDTH; reads zero-extend to 32. Counter never passes RELOAD in up mode unless software writes COUNT > RELOAD, in which case it counts up to 2^WIDTH-1, wraps to 0 with no event, then proceeds normally.
- Address decoding: channel index ≥ CHANNELS reads 0 and ignores writes.
- Simultaneous events:
  - COUNT write on a tick edge: write wins, no event.
  - W1C on the same edge as an event: set wins, flag=1.
  - reg_read and reg_write asserted together: the write is performed; the read returns the pre-write value.
- Any CONFIG write clears that channel's prescale counter.
- Reset: all COUNT, CONFIG, RELOAD, flags and prescale counters = 0; reg_read_valid=0; reg_data_out=0; irq=0. Reset mid-count aborts immediately; no event is generated.

## Timing
- Read: reg_read sampled at edge N; reg_read_valid=1 and reg_data_out valid during cycle N→N+1. Data reflects state before edge N.
- Write: takes effect at the sampling edge; a read issued the next cycle returns the new value.
- CONFIG write enabling at edge N: first tick at edge N+1+P.
- Event at edge E: flag=1 after E; irq=1 after E+1 (registered). irq deasserts one edge after the flag is cleared or irq_en is cleared.
- Channels are fully independent; no cross-channel ordering.

## Test plan
- Reset: hold reset 10 cycles mid-count with irq high → all registers read 0, irq=0 after the first reset edge; read a nonexistent channel (CHANNELS=3, channel 3) → 0.
- Up count, P=0: RELOAD=5, CONFIG=0b111 → COUNT sequence 1,2,3,4,5,0; flag set on the 5→0 edge; irq high 1 cycle later; W1C STATUS=1 → irq low 1 cycle later.
- Down count with prescale: RELOAD=3, COUNT=2, CONFIG=(P=4)|0b001 → COUNT decrements every 5 cycles, 2,1,0,3; event on the 0→3 transition; irq stays 0 (irq_en=0).
- One-shot: RELOAD=2, CONFIG=0b1011 → after event COUNT=0, CONFIG[0]=0, STATUS=0b01, COUNT frozen for 50 cycles.
- Collisions: a W1C coinciding with an event edge leaves flag=1; a COUNT write of 7 on a tick edge reads back 7; a simultaneous read+write of RELOAD returns the old value.
- Parameter sweep: WIDTH=8, CHANNELS=16; write COUNT=0x1FF → reads 0xFF. Up count from 0xFF with RELOAD=0x10 wraps to 0 with no event. All 16 channels run concurrently with distinct P; irq is the OR of the enabled flags.
